lcd_nibble_driver: RTL and testbench
====================================

Name: lcd_nibble_driver

Overview:
- Drives the Spartan-3E character LCD over its 4-bit interface on behalf of MiniAlu.
- Accepts whole bytes (command or data) from MiniAlu through a write/ready handshake.
- Runs the LCD power-on initialisation nibble sequence itself.
- Splits each byte into high and low nibbles, generates E pulses and inter-nibble/inter-byte delays, and drives the LCD pins directly.

Parameters:
P_SETUP, 2, cycles RS/data stable before E rises (40 ns @ 50 MHz)
P_PULSE, 12, cycles E held high (240 ns)
P_HOLD, 1, cycles RS/data held after E falls
P_NIBBLE_GAP, 50, idle cycles between high and low nibble (1 us)
P_BYTE_GAP, 2000, idle cycles after low nibble before next byte (40 us)
P_POWERUP, 750000, cycles after reset before first init nibble (15 ms)
P_INIT_LONG, 205000, wait after init nibble 0 (4.1 ms)
P_INIT_MID, 5000, wait after init nibble 1 (100 us)
P_INIT_SHORT, 2000, wait after init nibbles 2 and 3 (40 us)
P_CNT_W, 20, delay counter width; must hold the largest delay parameter

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
iWrite  input  1  byte write request, sampled only while oReady=1
iData  input  8  byte to send; captured with iWrite
iRS  input  1  register select for byte (0 command, 1 data); captured with iWrite
oReady  output  1  high when a new byte can be accepted
oLCD_Enabled  output  1  LCD E strobe
oLCD_RegisterSelect  output  1  LCD RS
oLCD_StrataFlashControl  output  1  StrataFlash CE; constant 1 (flash disabled, LCD owns the bus)
oLCD_ReadWrite  output  1  LCD R/W; constant 0 (write only)
oLCD_Data  output  4  LCD DB[7:4]

Behaviour:
- Single clock domain (Clock). Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - oReady=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0.
  - oLCD_StrataFlashControl=1, oLCD_ReadWrite=0.
  - FSM in PWR_WAIT, delay counter=0, init index=0.
- FSM states: PWR_WAIT, SETUP, PULSE, HOLD, WAIT, IDLE.
- A nibble emission is SETUP (P_SETUP cycles, E=0) -> PULSE (P_PULSE cycles, E=1) -> HOLD (P_HOLD cycles, E=0) -> WAIT (N cycles, E=0).
- The delay counter counts 0..len-1 in each state, then advances.
- PWR_WAIT: lasts P_POWERUP cycles, then emits init nibbles 0x3, 0x3, 0x3, 0x2, all with RS=0.
  - WAIT lengths after them: P_INIT_LONG, P_INIT_MID, P_INIT_SHORT, P_INIT_SHORT.
  - After the last init wait, go to IDLE.
- IDLE: oReady=1.
  - If iWrite=1 at a rising edge: capture iData/iRS; oReady=0 from that edge.
  - Emit the high nibble (iData[7:4]) with WAIT=P_NIBBLE_GAP.
  - Then emit the low nibble (iData[3:0]) with WAIT=P_BYTE_GAP, then return to IDLE.
- Byte latency: oReady reasserts exactly T_BYTE = 2*(P_SETUP+P_PULSE+P_HOLD)+P_NIBBLE_GAP+P_BYTE_GAP cycles after the accepting edge (2080 at defaults).
- Init latency: first oReady=1 exactly T_INIT = P_POWERUP+4*(P_SETUP+P_PULSE+P_HOLD)+P_INIT_LONG+P_INIT_MID+2*P_INIT_SHORT cycles after Reset deasserts.
- oLCD_Data and oLCD_RegisterSelect:
  - Load on entry to SETUP.
  - Stable through SETUP, PULSE, HOLD.
  - Keep the last value through WAIT and IDLE.
- iWrite while oReady=0 is ignored; no queueing, no error flag.
- iWrite held high across IDLE entry is accepted on the first IDLE cycle.
- iData/iRS changes after capture have no effect on the byte in flight.
- Exactly two E pulses per byte, each P_PULSE cycles wide. E is never high outside PULSE.
- Reset asserted mid-byte or mid-init: at that edge E=0 and all reset values apply. The full power-up sequence then reruns; the partial byte is discarded.

Test Plan:
Bench parameters: P_POWERUP=200, P_INIT_LONG=80, P_INIT_MID=40, P_INIT_SHORT=20, P_NIBBLE_GAP=50, P_BYTE_GAP=100, others default. This gives T_INIT=420 and T_BYTE=180.

1. Reset 2 cycles, release -> oReady rises at cycle 420. Exactly 4 E pulses, 12 cycles each, data 3,3,3,2, RS=0. oLCD_StrataFlashControl=1 and oLCD_ReadWrite=0 throughout.
2. After init, iWrite=1 for 1 cycle with iData=0x28, iRS=0:
   - oReady=0 next cycle.
   - E pulses carry data 0x2 then 0x8, RS=0.
   - E rises 65 cycles apart.
   - oReady=1 again 180 cycles after accept.
3. iData=0x41, iRS=1, with iData changed to 0xFF 3 cycles after accept -> LCD receives 0x4 then 0x1, RS=1 during both pulses.
4. iWrite pulsed repeatedly while oReady=0 during byte 0x0C -> only 2 E pulses occur. The second request is not sent until oReady=1 and iWrite=1 coincide.
5. iWrite held high continuously with iData=0x01 -> a new byte starts every 181 cycles (180 busy + 1 IDLE cycle); E pulse count grows by 2 per byte.
6. Reset asserted during PULSE of the low nibble -> E=0 on the same edge. Outputs return to reset values, and oReady next rises 420 cycles after Reset deasserts.

Source files
------------

// File: rtl/lcd_nibble_driver.sv
// ---------------------------------------------------------------------------
// lcd_nibble_driver
//
// Drives the Spartan-3E character LCD through its 4-bit interface for MiniAlu.
// After reset the block waits for the LCD to power up and then plays the
// 4-bit initialisation nibbles (3, 3, 3, 2). After that it accepts whole bytes
// through a write/ready handshake. Each byte is sent as a high nibble and then
// a low nibble. Every nibble is one E strobe, framed by setup, hold and wait
// times.
//
// Ports
//   Clock                    system clock
//   Reset                    synchronous, active-high reset
//   iWrite                   byte write request, sampled only while oReady=1
//   iData[7:0]               byte to send, captured together with iWrite
//   iRS                      register select for the byte (0 cmd, 1 data)
//   oReady                   high when a new byte can be accepted
//   oLCD_Enabled             LCD E strobe
//   oLCD_RegisterSelect      LCD RS
//   oLCD_StrataFlashControl  StrataFlash CE, held at 1 so the LCD owns the bus
//   oLCD_ReadWrite           LCD R/W, held at 0 (write only)
//   oLCD_Data[3:0]           LCD DB[7:4]
// ---------------------------------------------------------------------------
module lcd_nibble_driver #(
    parameter int P_SETUP      = 2,
    parameter int P_PULSE      = 12,
    parameter int P_HOLD       = 1,
    parameter int P_NIBBLE_GAP = 50,
    parameter int P_BYTE_GAP   = 2000,
    parameter int P_POWERUP    = 750000,
    parameter int P_INIT_LONG  = 205000,
    parameter int P_INIT_MID   = 5000,
    parameter int P_INIT_SHORT = 2000,
    parameter int P_CNT_W      = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic [7:0] iData,
    input  logic       iRS,
    output logic       oReady,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    // Terminal counts: every state counts 0..len-1 and leaves on len-1.
    localparam logic [P_CNT_W-1:0] L_SETUP      = P_CNT_W'(P_SETUP - 1);
    localparam logic [P_CNT_W-1:0] L_PULSE      = P_CNT_W'(P_PULSE - 1);
    localparam logic [P_CNT_W-1:0] L_HOLD       = P_CNT_W'(P_HOLD - 1);
    localparam logic [P_CNT_W-1:0] L_NIBBLE_GAP = P_CNT_W'(P_NIBBLE_GAP - 1);
    localparam logic [P_CNT_W-1:0] L_BYTE_GAP   = P_CNT_W'(P_BYTE_GAP - 1);
    localparam logic [P_CNT_W-1:0] L_POWERUP    = P_CNT_W'(P_POWERUP - 1);
    localparam logic [P_CNT_W-1:0] L_INIT_LONG  = P_CNT_W'(P_INIT_LONG - 1);
    localparam logic [P_CNT_W-1:0] L_INIT_MID   = P_CNT_W'(P_INIT_MID - 1);
    localparam logic [P_CNT_W-1:0] L_INIT_SHORT = P_CNT_W'(P_INIT_SHORT - 1);

    // Nibble step index: 0..3 are the init nibbles, 4 is the high nibble of
    // the captured byte and 5 is its low nibble. The step selects both the
    // nibble value and the length of the WAIT that follows it.
    localparam logic [2:0] STEP_LAST_INIT = 3'd3;
    localparam logic [2:0] STEP_HIGH      = 3'd4;
    localparam logic [2:0] STEP_LOW       = 3'd5;

    state_t             state_q, state_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         step_q, step_d;
    logic [7:0]         byte_q, byte_d;
    logic               byte_rs_q, byte_rs_d;
    logic               ready_q, ready_d;
    logic               en_q, en_d;
    logic               rs_q, rs_d;
    logic [3:0]         data_q, data_d;

    logic [P_CNT_W-1:0] last_cnt;
    logic               at_last;

    // Value put on DB[7:4] for a given step.
    function automatic logic [3:0] nibble_for(input logic [2:0] step,
                                              input logic [7:0] byte_val);
        logic [3:0] nib;
        case (step)
            3'd0, 3'd1, 3'd2: nib = 4'h3;
            3'd3:             nib = 4'h2;
            STEP_HIGH:        nib = byte_val[7:4];
            default:          nib = byte_val[3:0];
        endcase
        return nib;
    endfunction

    // Length of the WAIT that follows the nibble of a given step.
    function automatic logic [P_CNT_W-1:0] wait_last_for(input logic [2:0] step);
        logic [P_CNT_W-1:0] len;
        case (step)
            3'd0:      len = L_INIT_LONG;
            3'd1:      len = L_INIT_MID;
            3'd2, 3'd3: len = L_INIT_SHORT;
            STEP_HIGH: len = L_NIBBLE_GAP;
            default:   len = L_BYTE_GAP;
        endcase
        return len;
    endfunction

    always_comb begin
        last_cnt = '0;
        case (state_q)
            PWR_WAIT: last_cnt = L_POWERUP;
            SETUP:    last_cnt = L_SETUP;
            PULSE:    last_cnt = L_PULSE;
            HOLD:     last_cnt = L_HOLD;
            WAIT:     last_cnt = wait_last_for(step_q);
            default:  last_cnt = '0;
        endcase
        at_last = (cnt_q == last_cnt);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        step_d    = step_q;
        byte_d    = byte_q;
        byte_rs_d = byte_rs_q;
        rs_d      = rs_q;
        data_d    = data_q;

        case (state_q)
            PWR_WAIT: begin
                if (at_last) begin
                    state_d = SETUP;
                    step_d  = 3'd0;
                end
            end
            SETUP: begin
                if (at_last) state_d = PULSE;
            end
            PULSE: begin
                if (at_last) state_d = HOLD;
            end
            HOLD: begin
                if (at_last) state_d = WAIT;
            end
            WAIT: begin
                if (at_last) begin
                    if (step_q == STEP_LAST_INIT || step_q == STEP_LOW) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SETUP;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            IDLE: begin
                if (iWrite) begin
                    state_d   = SETUP;
                    step_d    = STEP_HIGH;
                    byte_d    = iData;
                    byte_rs_d = iRS;
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Pins change only when a nibble starts; they keep their last value
        // through WAIT and IDLE.
        if (state_d == SETUP && state_q != SETUP) begin
            data_d = nibble_for(step_d, byte_d);
            rs_d   = (step_d >= STEP_HIGH) ? byte_rs_d : 1'b0;
        end

        en_d    = (state_d == PULSE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= PWR_WAIT;
            cnt_q     <= '0;
            step_q    <= 3'd0;
            byte_q    <= 8'h00;
            byte_rs_q <= 1'b0;
            ready_q   <= 1'b0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            byte_q    <= byte_d;
            byte_rs_q <= byte_rs_d;
            ready_q   <= ready_d;
            en_q      <= en_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
        end
    end

    assign oReady                  = ready_q;
    assign oLCD_Enabled            = en_q;
    assign oLCD_RegisterSelect     = rs_q;
    assign oLCD_Data               = data_q;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_nibble_driver
//
// Randomised bench for lcd_nibble_driver, built with short timing parameters.
// The reference model does not follow the state machine. It works from
// timestamps: a reset or an accepted byte sets the cycle at which oReady must
// return, and adds the expected E pulses (start cycle, nibble, RS) to a queue.
// The outputs are compared against that model on every falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_nibble_driver;

    localparam int P_SETUP      = 2;
    localparam int P_PULSE      = 12;
    localparam int P_HOLD       = 1;
    localparam int P_NIBBLE_GAP = 50;
    localparam int P_BYTE_GAP   = 100;
    localparam int P_POWERUP    = 200;
    localparam int P_INIT_LONG  = 80;
    localparam int P_INIT_MID   = 40;
    localparam int P_INIT_SHORT = 20;
    localparam int P_CNT_W      = 20;

    localparam int T_NIB  = P_SETUP + P_PULSE + P_HOLD;
    localparam int T_BYTE = 2 * T_NIB + P_NIBBLE_GAP + P_BYTE_GAP;
    localparam int T_INIT = P_POWERUP + 4 * T_NIB + P_INIT_LONG + P_INIT_MID + 2 * P_INIT_SHORT;

    logic       Clock;
    logic       Reset;
    logic       iWrite;
    logic [7:0] iData;
    logic       iRS;
    logic       oReady;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    lcd_nibble_driver #(
        .P_SETUP      (P_SETUP),
        .P_PULSE      (P_PULSE),
        .P_HOLD       (P_HOLD),
        .P_NIBBLE_GAP (P_NIBBLE_GAP),
        .P_BYTE_GAP   (P_BYTE_GAP),
        .P_POWERUP    (P_POWERUP),
        .P_INIT_LONG  (P_INIT_LONG),
        .P_INIT_MID   (P_INIT_MID),
        .P_INIT_SHORT (P_INIT_SHORT),
        .P_CNT_W      (P_CNT_W)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iWrite                  (iWrite),
        .iData                   (iData),
        .iRS                     (iRS),
        .oReady                  (oReady),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_Data               (oLCD_Data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, want);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int         start;
        logic [3:0] d;
        logic       rs;
    } pulse_t;

    pulse_t exp_q[$];
    int     cyc      = 0;
    int     ready_at = 0;
    bit     started  = 1'b0;
    int     init_nib  [4] = '{3, 3, 3, 2};
    int     init_wait [4] = '{P_INIT_LONG, P_INIT_MID, P_INIT_SHORT, P_INIT_SHORT};
    int     e_rises   = 0;

    always @(posedge Clock) begin
        int t;
        pulse_t p;
        cyc = cyc + 1;
        if (Reset) begin
            started  = 1'b1;
            ready_at = cyc + T_INIT;
            exp_q.delete();
            t = cyc + P_POWERUP + P_SETUP;
            for (int i = 0; i < 4; i++) begin
                p.start = t; p.d = 4'(init_nib[i]); p.rs = 1'b0;
                exp_q.push_back(p);
                t = t + P_PULSE + P_HOLD + init_wait[i] + P_SETUP;
            end
        end else if (started && iWrite && (cyc - 1 >= ready_at)) begin
            $display("byte %02h rs=%0d accepted at cycle %0d", iData, iRS, cyc);
            ready_at = cyc + T_BYTE;
            p.start = cyc + P_SETUP; p.d = iData[7:4]; p.rs = iRS;
            exp_q.push_back(p);
            p.start = cyc + T_NIB + P_NIBBLE_GAP + P_SETUP; p.d = iData[3:0];
            exp_q.push_back(p);
        end
    end

    logic en_prev = 1'b0;

    always @(negedge Clock) begin
        bit exp_e;
        if (started) begin
            while (exp_q.size() > 0 && exp_q[0].start + P_PULSE <= cyc) void'(exp_q.pop_front());
            exp_e = (exp_q.size() > 0) && (exp_q[0].start <= cyc);
            chk("E", oLCD_Enabled, exp_e);
            if (exp_e) begin
                chk("DB", oLCD_Data, exp_q[0].d);
                chk("RS", oLCD_RegisterSelect, exp_q[0].rs);
            end
            chk("RDY", oReady, (cyc >= ready_at));
            chk("SF", oLCD_StrataFlashControl, 1'b1);
            chk("RW", oLCD_ReadWrite, 1'b0);
            if (oLCD_Enabled && !en_prev) e_rises++;
        end
        en_prev = oLCD_Enabled;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_ready(input int budget);
        int n = 0;
        while (!oReady && n < budget) begin
            @(negedge Clock);
            n++;
        end
        chk("ready_timeout", oReady, 1'b1);
    endtask

    // Returns after the negedge that follows the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic rs);
        wait_ready(T_BYTE + T_INIT + 10);
        iWrite = 1'b1; iData = d; iRS = rs;
        @(negedge Clock);
        iWrite = 1'b0;
        chk("ready_drop", oReady, 1'b0);
    endtask

    initial begin
        int rel;
        int rises0;
        Reset = 1'b1; iWrite = 1'b0; iData = 8'h00; iRS = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_db", oLCD_Data, 4'h0);
        chk("rst_rs", oLCD_RegisterSelect, 1'b0);
        chk("rst_rdy", oReady, 1'b0);
        Reset = 1'b0;
        rel = cyc;

        // Power-up sequence: oReady must rise exactly T_INIT cycles after release.
        wait_ready(T_INIT + 50);
        chk("t_init", cyc - rel, T_INIT);
        chk("init_pulses", e_rises, 4);

        // Command byte 0x28.
        rises0 = e_rises;
        send_byte(8'h28, 1'b0);
        wait_ready(T_BYTE + 10);
        chk("byte_pulses", e_rises - rises0, 2);

        // Data byte 0x41; inputs scrambled shortly after capture.
        send_byte(8'h41, 1'b1);
        repeat (2) @(negedge Clock);
        iData = 8'hFF; iRS = 1'b0;
        wait_ready(T_BYTE + 10);

        // Requests while busy are ignored.
        rises0 = e_rises;
        send_byte(8'h0C, 1'b0);
        for (int i = 0; i < 20 && !oReady; i++) begin
            repeat ($urandom_range(2, 6)) @(negedge Clock);
            if (!oReady) begin
                iWrite = 1'b1; iData = 8'($urandom); iRS = 1'($urandom);
                @(negedge Clock);
                iWrite = 1'b0;
            end
        end
        wait_ready(T_BYTE + 10);
        chk("busy_ignored", e_rises - rises0, 2);

        // iWrite held high: back-to-back bytes.
        rises0 = e_rises;
        iWrite = 1'b1; iData = 8'h01; iRS = 1'b1;
        repeat (3 * (T_BYTE + 1)) @(negedge Clock);
        iWrite = 1'b0;
        wait_ready(T_BYTE + 10);
        chk("held_pulses", e_rises - rises0, 6);

        // Random bytes with random gaps and busy-time noise.
        for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 4)) @(negedge Clock);
            send_byte(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 150)) @(negedge Clock);
                if (!oReady) begin
                    iWrite = 1'b1; iData = 8'($urandom);
                    @(negedge Clock);
                    iWrite = 1'b0;
                end
            end
        end

        // Reset during the low-nibble pulse.
        wait_ready(T_BYTE + 10);
        send_byte(8'h5A, 1'b1);
        repeat (P_SETUP + T_NIB + P_NIBBLE_GAP + 3) @(negedge Clock);
        chk("mid_pulse_e", oLCD_Enabled, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("rst_e", oLCD_Enabled, 1'b0);
        chk("rst_db2", oLCD_Data, 4'h0);
        chk("rst_rdy2", oReady, 1'b0);
        Reset = 1'b0;
        rel = cyc;
        rises0 = e_rises;
        wait_ready(T_INIT + 50);
        chk("t_init2", cyc - rel, T_INIT);
        chk("init_pulses2", e_rises - rises0, 4);

        send_byte(8'hC3, 1'b0);
        wait_ready(T_BYTE + 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
